// File: rtl/adaptive_phase_ctrl_pkg.sv
// Shared types and helpers for the adaptive traffic-phase controller.
// Optional build macro consumed by the top: PHASE_PREEMPT_EN.
package phase_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED,
    ST_GREEN,
    ST_YELLOW
  } phase_state_e;

  // Direction vectors are carried at a fixed width so helpers stay parameter-free.
  localparam int MAX_DIRS = 32;
  typedef logic [MAX_DIRS-1:0] dir_vec_t;

  function automatic int sum_width(int cnt_w, int lanes);
    return cnt_w + $clog2(lanes) + 1;
  endfunction

  function automatic int onehot_to_idx(dir_vec_t v);
    int idx = 0;
    for (int i = 0; i < MAX_DIRS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic dir_vec_t idx_to_onehot(int idx);
    return dir_vec_t'(1) << idx;
  endfunction

  function automatic logic is_onehot(dir_vec_t v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/adaptive_phase_ctrl_dir_argmax.sv
// Combinational busiest-direction finder: sums each direction's lanes and picks
// the largest non-excluded sum, lowest index on ties; zero sums never win.
module dir_argmax
  import phase_ctrl_pkg::*;
#(
  parameter int NUM_DIR       = 4,
  parameter int LANES_PER_DIR = 2,
  parameter int CNT_W         = 8,
  localparam int IDX_W        = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic [NUM_DIR*LANES_PER_DIR*CNT_W-1:0] lane_cnt_i,
  input  logic [NUM_DIR-1:0]                     exclude_i,
  output logic [IDX_W-1:0]                       idx_o,
  output logic                                   demand_o
);

  localparam int SUM_W = sum_width(CNT_W, LANES_PER_DIR);

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] best;

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    idx_o    = '0;
    demand_o = 1'b0;
    best     = '0;
    sum      = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      sum = '0;
      for (int l = 0; l < LANES_PER_DIR; l++) begin
        sum = sum + SUM_W'(lane_cnt_i[(d*LANES_PER_DIR+l)*CNT_W +: CNT_W]);
      end
      // Strict compare keeps the lowest index on ties and rejects empty directions.
      if (!exclude_i[d] && sum > best) begin
        best     = sum;
        idx_o    = IDX_W'(d);
        demand_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adaptive_phase_ctrl.sv
// Adaptive traffic-phase controller: green -> yellow -> all-red sequencing toward
// the busiest waiting direction. Optional macro PHASE_PREEMPT_EN adds preemption.
module adaptive_phase_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter int NUM_DIR       = 4,
  parameter int LANES_PER_DIR = 2,
  parameter int CNT_W         = 8,
  parameter int MIN_GREEN     = 4,
  parameter int MAX_GREEN     = 12,
  parameter int YELLOW        = 3,
  parameter int ALL_RED       = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_DIR*LANES_PER_DIR*CNT_W-1:0] lane_cnt,
  output logic [NUM_DIR*LANES_PER_DIR-1:0]       green,
  output logic [NUM_DIR*LANES_PER_DIR-1:0]       yellow,
  output logic [NUM_DIR-1:0]                     cur_dir,
  output logic                                   phase_start
`ifdef PHASE_PREEMPT_EN
  ,
  input  logic                                   preempt_req,
  input  logic [NUM_DIR-1:0]                     preempt_dir
`endif
);

  localparam int NL      = NUM_DIR * LANES_PER_DIR;
  localparam int IDX_W   = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;
  localparam int SUM_W   = sum_width(CNT_W, LANES_PER_DIR);
  localparam int TMR_A   = (MAX_GREEN > YELLOW) ? MAX_GREEN : YELLOW;
  localparam int TMR_MAX = (TMR_A > ALL_RED) ? TMR_A : ALL_RED;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  phase_state_e     state_q;
  logic [TMR_W-1:0] timer_q;
  logic [IDX_W-1:0] cur_idx_q;
  logic [IDX_W-1:0] next_idx_q;
  logic             after_reset_q;

  logic [IDX_W-1:0] oth_idx, all_idx, sel_idx, pre_idx;
  logic             oth_dem, all_dem, pre_valid;
  logic [NUM_DIR-1:0] pre_dir;
  logic [SUM_W-1:0] cur_sum;
  logic             green_done, pre_switch, pre_hold;
  int               t_cur;

  function automatic logic [NL-1:0] lanes_of(logic [IDX_W-1:0] d);
    logic [NL-1:0] m = '0;
    for (int i = 0; i < NL; i++) m[i] = (i / LANES_PER_DIR == int'(d));
    return m;
  endfunction

  function automatic logic [NUM_DIR-1:0] dir_of(logic [IDX_W-1:0] d);
    dir_vec_t oh = idx_to_onehot(int'(d));
    return oh[NUM_DIR-1:0];
  endfunction

  dir_argmax #(.NUM_DIR(NUM_DIR), .LANES_PER_DIR(LANES_PER_DIR), .CNT_W(CNT_W)) u_other (
    .lane_cnt_i (lane_cnt),
    .exclude_i  (cur_dir),
    .idx_o      (oth_idx),
    .demand_o   (oth_dem)
  );

  dir_argmax #(.NUM_DIR(NUM_DIR), .LANES_PER_DIR(LANES_PER_DIR), .CNT_W(CNT_W)) u_all (
    .lane_cnt_i (lane_cnt),
    .exclude_i  ('0),
    .idx_o      (all_idx),
    .demand_o   (all_dem)
  );

`ifdef PHASE_PREEMPT_EN
  dir_vec_t pre_vec;
  assign pre_vec   = dir_vec_t'(preempt_dir);
  assign pre_valid = preempt_req && is_onehot(pre_vec);
  assign pre_idx   = IDX_W'(onehot_to_idx(pre_vec));
  assign pre_dir   = preempt_dir;
`else
  assign pre_valid = 1'b0;
  assign pre_idx   = '0;
  assign pre_dir   = '0;
`endif

  always_comb begin
    cur_sum = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      for (int l = 0; l < LANES_PER_DIR; l++) begin
        if (cur_dir[d]) cur_sum = cur_sum + SUM_W'(lane_cnt[(d*LANES_PER_DIR+l)*CNT_W +: CNT_W]);
      end
    end
  end

  always_comb begin
    if (pre_valid)          sel_idx = pre_idx;
    else if (after_reset_q) sel_idx = all_dem ? all_idx : '0;
    else                    sel_idx = next_idx_q;
  end

  assign t_cur      = int'(timer_q) + 1;
  assign green_done = oth_dem && ((t_cur >= MIN_GREEN && cur_sum == '0) || t_cur >= MAX_GREEN);
  assign pre_switch = pre_valid && (pre_dir != cur_dir);
  assign pre_hold   = pre_valid && (pre_dir == cur_dir);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ALL_RED;
      timer_q       <= '0;
      cur_idx_q     <= '0;
      next_idx_q    <= '0;
      after_reset_q <= 1'b1;
      green         <= '0;
      yellow        <= '0;
      cur_dir       <= '0;
      phase_start   <= 1'b0;
    end else begin
      phase_start <= 1'b0;
      // The timer saturates so an indefinitely held green never wraps.
      if (int'(timer_q) < TMR_MAX) timer_q <= timer_q + 1'b1;
      case (state_q)
        ST_ALL_RED: begin
          if (pre_valid) begin
            next_idx_q    <= pre_idx;
            after_reset_q <= 1'b0;
          end
          if (int'(timer_q) >= ALL_RED - 1) begin
            state_q       <= ST_GREEN;
            timer_q       <= '0;
            after_reset_q <= 1'b0;
            cur_idx_q     <= sel_idx;
            cur_dir       <= dir_of(sel_idx);
            green         <= lanes_of(sel_idx);
            phase_start   <= 1'b1;
          end
        end
        ST_GREEN: begin
          if (pre_switch || (!pre_hold && green_done)) begin
            state_q    <= ST_YELLOW;
            timer_q    <= '0;
            next_idx_q <= pre_switch ? pre_idx : oth_idx;
            green      <= '0;
            yellow     <= lanes_of(cur_idx_q);
          end
        end
        ST_YELLOW: begin
          if (pre_valid) next_idx_q <= pre_idx;
          if (int'(timer_q) >= YELLOW - 1) begin
            state_q <= ST_ALL_RED;
            timer_q <= '0;
            yellow  <= '0;
          end
        end
        default: begin
          state_q <= ST_ALL_RED;
          timer_q <= '0;
          green   <= '0;
          yellow  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/adaptive_phase_ctrl.md
# adaptive_phase_ctrl

Parametrised adaptive traffic-phase controller, the next generation of the day-time lane selector. It sums per-lane car counts per direction and grants green to the busiest waiting direction, never the one just served. It sequences a full green → yellow → all-red cycle with minimum and maximum green times. It sits between the lane-count sensors and the light drivers, and replaces the day-time selector for any direction or lane count.

## Interface
Parameters:
- NUM_DIR, 4, number of approach directions; index 0=N, 1=E, 2=S, 3=W for the default.
- LANES_PER_DIR, 2, lanes per direction. Lane index is d*LANES_PER_DIR+l.
- CNT_W, 8, width of each lane count.
- MIN_GREEN, 4, minimum green cycles.
- MAX_GREEN, 12, maximum green cycles when other demand exists. Must be ≥ MIN_GREEN.
- YELLOW, 3, yellow cycles.
- ALL_RED, 1, all-red cycles, ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- lane_cnt  in  NUM_DIR*LANES_PER_DIR*CNT_W  packed lane counts; lane i at bits [i*CNT_W +: CNT_W].
- green  out  NUM_DIR*LANES_PER_DIR  per-lane green. All lanes of the active direction are set together.
- yellow  out  NUM_DIR*LANES_PER_DIR  per-lane yellow.
- cur_dir  out  NUM_DIR  one-hot direction of the current or last green phase.
- phase_start  out  1  one-cycle pulse on the first green cycle of each phase.

## Operation
- Direction sum: unsigned sum of that direction's lanes, width CNT_W+$clog2(LANES_PER_DIR)+1. No overflow is possible.
- Argmax: the largest sum over enabled directions wins. Ties go to the lowest index. If every enabled sum is 0, the result is "no demand".
- States are ALL_RED, GREEN, YELLOW. Each state has a phase timer that is cleared on state entry and saturates at MAX_GREEN.
- ALL_RED:
  - Lasts ALL_RED cycles.
  - On the last cycle, next_dir is taken from a latched register, except after reset.
  - After reset, next_dir = argmax over all directions; with no demand, next_dir = 0.
  - Then enter GREEN for next_dir and pulse phase_start.
- GREEN: let other = argmax excluding the current direction.
  - Leave to YELLOW at the end of cycle t, counted from 1, when other has demand and one of these holds:
    - t ≥ MIN_GREEN and the current direction's sum == 0, or
    - t ≥ MAX_GREEN.
  - No other demand: hold green indefinitely.
  - On the transition, latch next_dir = other.
- YELLOW: lasts YELLOW cycles with the current direction's yellow lanes set, then enters ALL_RED.
- Selection uses lane_cnt sampled on the deciding cycle only. Count changes during yellow or all-red do not alter the latched next_dir.
- A direction never gets two consecutive green phases unless it is the only direction with demand, in which case it is held.

## Timing
- All outputs are registered.
- Reset values: green=0, yellow=0, cur_dir=0, phase_start=0, state=ALL_RED, timer=0.
- rst asserted mid-phase: on the next edge all outputs are 0 and the state is ALL_RED. No yellow is issued.
- First green appears ALL_RED cycles after the cycle in which rst is low.
- GREEN→YELLOW:
  - The deciding condition is evaluated on cycle t.
  - green clears and yellow sets on the edge ending cycle t.
  - Green length is exactly t cycles.
- Minimum full phase = MIN_GREEN+YELLOW+ALL_RED cycles.
- green and yellow are never both set. At most one direction is active.

## Configuration
- PHASE_PREEMPT_EN defined:
  - Adds ports preempt_req (in, 1) and preempt_dir (in, NUM_DIR, one-hot).
  - If preempt_req is high while GREEN on a different direction, go to YELLOW next edge, ignoring MIN_GREEN. next_dir = preempt_dir.
  - If preempt_req is high while GREEN on preempt_dir, hold green and ignore MAX_GREEN for as long as preempt_req stays high.
  - If preempt_req is high during YELLOW or ALL_RED, next_dir is overridden with preempt_dir.
  - Invalid (non-one-hot) preempt_dir is ignored.
- Undefined: the ports are absent and the behaviour is as above.

## Structure
- Package phase_ctrl_pkg holds:
  - the state enum (ALL_RED, GREEN, YELLOW);
  - a sum-width function;
  - the one-hot/index conversion functions.
- One sub-module, dir_argmax. It is combinational: lane counts plus an exclude mask in, winning index plus a demand flag out. It is instantiated twice: excluding the current direction, and excluding none (used after reset).

## Test plan
- Reset, then counts N=(3,2), E=(10,0), rest 0 → after 1 all-red cycle: green[3:2]=2'b11, cur_dir=4'b0010, phase_start pulses once.
- E green, E drops to 0 at cycle 2, S=(1,1) → E green stays until cycle 4 (MIN_GREEN), then 3 yellow cycles, 1 all-red cycle, then S green.
- E green with E=(5,5), W=(1,0) constant → E green exactly 12 cycles, then W green. E is not re-chosen even though it has the larger sum.
- Only N has demand → N green is held for 100+ cycles, and yellow never asserts.
- Tie E=S=7 while N is green → E is selected (lowest index).
- rst pulse during yellow → next cycle all outputs are 0. Then all-red and a fresh argmax. With PHASE_PREEMPT_EN: preempt_dir=W during N green at cycle 1 → yellow next edge, then W green held while preempt_req=1.
